// File: rtl/shift_serializer.sv
// -----------------------------------------------------------------------------
// shift_serializer
//
// Parallel-in, serial-out stage. Accepts one SIZE-bit word per valid/ready
// handshake, then drives it out one bit at a time on sout_o, holding each bit
// for BIT_CYCLES clocks, MSB-first or LSB-first. Reports frame completion with
// a one-cycle done_o pulse so upstream logic can reload it back to back.
//
// Parameters:
//   SIZE        data word width in bits (>= 2)
//   MSB_FIRST   1: bit SIZE-1 goes out first; 0: bit 0 goes out first
//   BIT_CYCLES  clocks each serial bit is held (>= 1)
//
// Optional feature (compile-time macro):
//   SHIFT_SERIALIZER_PARITY_EN  appends an even-parity bit (XOR of the
//                               captured word) after the data bits; the
//                               last/done indications move to that bit.
//
// Ports:
//   clk_i         in   1     clock, rising edge
//   reset_i       in   1     synchronous, active-high reset
//   din_i         in   SIZE  parallel word to serialize
//   din_valid_i   in   1     din_i valid this cycle
//   din_ready_o   out  1     block can accept a word (IDLE)
//   abort_i       in   1     drop the word in flight
//   sout_o        out  1     serial data bit (0 when not valid)
//   sout_valid_o  out  1     sout_o carries a frame bit
//   sout_last_o   out  1     current bit is the final bit of the frame
//   done_o        out  1     one-cycle pulse when a frame completes normally
// -----------------------------------------------------------------------------
module shift_serializer #(
    parameter int SIZE       = 8,
    parameter int MSB_FIRST  = 1,
    parameter int BIT_CYCLES = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [SIZE-1:0] din_i,
    input  logic            din_valid_i,
    output logic            din_ready_o,
    input  logic            abort_i,
    output logic            sout_o,
    output logic            sout_valid_o,
    output logic            sout_last_o,
    output logic            done_o
);

    // Bit counter must be able to hold SIZE (reached when parity follows
    // the data bits); hold counter needs at least one bit even when
    // BIT_CYCLES is 1.
    localparam int CNT_W  = $clog2(SIZE + 1);
    localparam int HOLD_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(SIZE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
`ifdef SHIFT_SERIALIZER_PARITY_EN
        ,
        ST_PARITY = 2'd2
`endif
    } state_e;

    state_e            state_q,    state_d;
    logic [SIZE-1:0]   shreg_q,    shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    logic              parity_q,   parity_d;
`endif

    logic            hold_done;
    logic            lead_bit;
    logic [SIZE-1:0] shreg_shifted;

    // Terminal count of the per-bit hold counter.
    assign hold_done = (hold_cnt_q == HOLD_LAST);

    // Leading bit is the one currently on the wire; shifting moves the next
    // bit into that position and zero-fills from the far end.
    assign lead_bit      = (MSB_FIRST != 0) ? shreg_q[SIZE-1] : shreg_q[0];
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg_q[SIZE-2:0], 1'b0}
                                            : {1'b0, shreg_q[SIZE-1:1]};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement so no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
`ifdef SHIFT_SERIALIZER_PARITY_EN
        parity_d   = parity_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // din_ready_o is 1 in IDLE, so valid alone completes the
                // handshake.
                if (din_valid_i) begin
                    state_d    = ST_SHIFT;
                    shreg_d    = din_i;
                    bit_cnt_d  = '0;
                    hold_cnt_d = '0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
                    parity_d   = ^din_i;
`endif
                end
            end

            ST_SHIFT: begin
                if (abort_i) begin
                    // Abort wins over a terminal count on the same edge.
                    state_d    = ST_IDLE;
                    shreg_d    = '0;
                    bit_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else if (!hold_done) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else begin
                    hold_cnt_d = '0;
                    shreg_d    = shreg_shifted;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
                        state_d   = ST_PARITY;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
`else
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end

`ifdef SHIFT_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (abort_i || hold_done) begin
                    state_d    = ST_IDLE;
                    shreg_d    = '0;
                    bit_cnt_d  = '0;
                    hold_cnt_d = '0;
                    parity_d   = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
`endif

            default: begin
                state_d    = ST_IDLE;
                shreg_d    = '0;
                bit_cnt_d  = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from registered state only, so there is no
    // combinational path from any input to any output. done_o marks the last
    // cycle of the final bit.
    // -------------------------------------------------------------------------
    always_comb begin
        din_ready_o  = 1'b0;
        sout_o       = 1'b0;
        sout_valid_o = 1'b0;
        sout_last_o  = 1'b0;
        done_o       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                din_ready_o = 1'b1;
            end
            ST_SHIFT: begin
                sout_valid_o = 1'b1;
                sout_o       = lead_bit;
`ifndef SHIFT_SERIALIZER_PARITY_EN
                sout_last_o  = (bit_cnt_q == LAST_BIT);
                done_o       = (bit_cnt_q == LAST_BIT) && hold_done;
`endif
            end
`ifdef SHIFT_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                sout_valid_o = 1'b1;
                sout_o       = parity_q;
                sout_last_o  = 1'b1;
                done_o       = hold_done;
            end
`endif
            default: begin
                din_ready_o = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers (synchronous reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples the values from
        // before this edge, independent of statement order.
        if (reset_i) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_shift_serializer.sv
// -----------------------------------------------------------------------------
// tb_shift_serializer
//
// Two instances: u_msb (SIZE=8, MSB_FIRST=1, BIT_CYCLES=1) and
// u_lsb (SIZE=8, MSB_FIRST=0, BIT_CYCLES=3). A select variable routes the
// shared stimulus to one of them and muxes its outputs for checking.
// Inputs are driven and outputs sampled at the falling edge.
// -----------------------------------------------------------------------------
module tb_shift_serializer;

    localparam int SIZE = 8;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    localparam int NBITS = SIZE + 1;
`else
    localparam int NBITS = SIZE;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic       valid = 1'b0;
    logic       abort = 1'b0;
    logic       sel = 1'b0;

    logic a_ready, a_sout, a_svalid, a_last, a_done;
    logic b_ready, b_sout, b_svalid, b_last, b_done;
    logic m_ready, m_sout, m_svalid, m_last, m_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_serializer #(.SIZE(8), .MSB_FIRST(1), .BIT_CYCLES(1)) u_msb (
        .clk_i(clk), .reset_i(reset), .din_i(din),
        .din_valid_i(valid & ~sel), .din_ready_o(a_ready),
        .abort_i(abort & ~sel), .sout_o(a_sout), .sout_valid_o(a_svalid),
        .sout_last_o(a_last), .done_o(a_done)
    );

    shift_serializer #(.SIZE(8), .MSB_FIRST(0), .BIT_CYCLES(3)) u_lsb (
        .clk_i(clk), .reset_i(reset), .din_i(din),
        .din_valid_i(valid & sel), .din_ready_o(b_ready),
        .abort_i(abort & sel), .sout_o(b_sout), .sout_valid_o(b_svalid),
        .sout_last_o(b_last), .done_o(b_done)
    );

    assign m_ready  = sel ? b_ready  : a_ready;
    assign m_sout   = sel ? b_sout   : a_sout;
    assign m_svalid = sel ? b_svalid : a_svalid;
    assign m_last   = sel ? b_last   : a_last;
    assign m_done   = sel ? b_done   : a_done;

    typedef struct {
        logic       dut_sel;  // 0: u_msb, 1: u_lsb
        logic [7:0] word;     // word presented on din
        logic [7:0] seq;      // expected wire order, leftmost bit first
        logic       par;      // expected even-parity bit
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ready"},  m_ready,  1'b1);
        check({tag, " svalid"}, m_svalid, 1'b0);
        check({tag, " sout"},   m_sout,   1'b0);
        check({tag, " last"},   m_last,   1'b0);
        check({tag, " done"},   m_done,   1'b0);
    endtask

    // Called at a falling edge in IDLE; returns at the falling edge of T+1.
    task automatic start_word(input logic [7:0] word, input bit hold_valid);
        check("accept ready", m_ready, 1'b1);
        din   = word;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid) valid = 1'b0;
    endtask

    // Checks every cycle of a full frame starting at T+1; returns at the
    // falling edge of the cycle after the final bit.
    task automatic check_bits(input logic [7:0] seq, input logic par);
        int  bc;
        logic exp_bit;
        logic exp_last;
        bc = sel ? 3 : 1;
        for (int k = 0; k < NBITS; k++) begin
            exp_bit  = (k < SIZE) ? seq[7-k] : par;
            exp_last = (k == NBITS - 1);
            for (int h = 0; h < bc; h++) begin
                check($sformatf("bit%0d.%0d sout", k, h), m_sout, exp_bit);
                check($sformatf("bit%0d.%0d svalid", k, h), m_svalid, 1'b1);
                check($sformatf("bit%0d.%0d last", k, h), m_last, exp_last);
                check($sformatf("bit%0d.%0d done", k, h), m_done,
                      exp_last && (h == bc - 1));
                check($sformatf("bit%0d.%0d ready", k, h), m_ready, 1'b0);
                @(negedge clk);
            end
        end
        check("post-frame ready", m_ready, 1'b1);
        check("post-frame svalid", m_svalid, 1'b0);
        check("post-frame done", m_done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 8'b10100101, 1'b0};
        vecs[1] = '{1'b0, 8'h3C, 8'b00111100, 1'b0};
        vecs[2] = '{1'b0, 8'h07, 8'b00000111, 1'b1};
        vecs[3] = '{1'b1, 8'h81, 8'b10000001, 1'b0};
        vecs[4] = '{1'b1, 8'h01, 8'b10000000, 1'b1};
        vecs[5] = '{1'b1, 8'h0E, 8'b01110000, 1'b1};

        // Reset: both instances held in reset, then released.
        repeat (3) @(negedge clk);
        sel = 1'b0; check_idle("reset msb");
        sel = 1'b1; check_idle("reset lsb");
        reset = 1'b0;
        @(negedge clk);
        sel = 1'b0; check_idle("release msb");
        sel = 1'b1; check_idle("release lsb");

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].dut_sel;
            start_word(vecs[i].word, 1'b0);
            check_bits(vecs[i].seq, vecs[i].par);
            @(negedge clk);
        end

        // Back-to-back FF then 00 with valid held high; din changes while
        // the first frame runs and must be ignored.
        sel = 1'b0;
        start_word(8'hFF, 1'b1);
        din = 8'h00;
        check_bits(8'hFF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        check_bits(8'h00, 1'b0);

        // Abort during cycle T+3 of an FF frame.
        @(negedge clk);
        start_word(8'hFF, 1'b0);
        check("abort T+1 sout", m_sout, 1'b1);
        @(negedge clk);
        check("abort T+2 sout", m_sout, 1'b1);
        @(negedge clk);
        check("abort T+3 sout", m_sout, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort T+4");
        @(negedge clk);
        check_idle("abort T+5");
        start_word(8'h0F, 1'b0);
        check_bits(8'h0F, 1'b0);

        // Reset pulsed in cycle T+5 of an A5 frame.
        @(negedge clk);
        start_word(8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst-frame bit%0d", k), m_sout, k[0] ? 1'b0 : 1'b1);
            @(negedge clk);
        end
        check("rst-frame bit4", m_sout, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("mid-frame reset");
        @(negedge clk);
        check_idle("after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
